// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer slice: FSM state encoding.
package counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear and inc together yield 1 (clear then count once).
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] base;

    always_comb begin
        base    = clear ? '0 : count_q;
        count_d = base;
        if (inc && (base != '1)) begin
            count_d = base + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with optional auto-reload, abort, registered
// terminal-count pulse and a saturating expiry counter.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic [WIDTH-1:0] expirations
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             exp_clear;
    logic             exp_inc;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        tc_d      = 1'b0;
        exp_clear = 1'b0;
        exp_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    exp_clear = 1'b1;
                    if (load_value != '0) begin
                        count_d  = load_value;
                        reload_d = load_value;
                        state_d  = ST_RUN;
                    end else begin
                        // Zero-length load expires immediately without leaving IDLE.
                        count_d = '0;
                        exp_inc = 1'b1;
                        tc_d    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (en) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        tc_d    = 1'b1;
                        exp_inc = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    sat_counter #(
        .WIDTH(WIDTH)
    ) u_expirations (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(exp_clear),
        .inc  (exp_inc),
        .count(expirations)
    );

    assign count      = count_q;
    assign tc         = tc_q;
    assign busy       = (state_q == ST_RUN);
    assign load_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: per-cycle vector table plus
// hand-written auto-reload and saturation sequences.
module tb_countdown_timer;

    typedef struct {
        bit       rst_n;
        bit       lv;
        bit [3:0] val;
        bit       ar;
        bit       en;
        bit       ab;
        bit [3:0] e_count;
        bit       e_busy;
        bit       e_tc;
        bit [3:0] e_exp;
        bit       e_rdy;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_value;
    logic       auto_reload;
    logic       en;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic [3:0] expirations;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    countdown_timer #(
        .WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .auto_reload(auto_reload),
        .en         (en),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .expirations(expirations)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit lv, input bit [3:0] val,
                         input bit ar, input bit e, input bit ab);
        rst_n       = r;
        load_valid  = lv;
        load_value  = val;
        auto_reload = ar;
        en          = e;
        abort       = ab;
    endtask

    function automatic vec_t mk(bit r, bit lv, bit [3:0] val, bit ar, bit e, bit ab,
                                bit [3:0] ec, bit eb, bit et, bit [3:0] ex, bit er);
        vec_t v;
        v.rst_n = r;  v.lv = lv; v.val = val; v.ar = ar; v.en = e; v.ab = ab;
        v.e_count = ec; v.e_busy = eb; v.e_tc = et; v.e_exp = ex; v.e_rdy = er;
        return v;
    endfunction

    initial begin
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        //                rst lv val ar en ab | cnt busy tc exp rdy
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1)); // reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
        // basic load of 5
        vecs.push_back(mk(1, 1, 5, 0, 1, 0,   5, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   4, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1));
        // hold then abort
        vecs.push_back(mk(1, 1, 6, 0, 1, 0,   6, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   5, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   4, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));
        // zero-length load
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1));
        // load request during RUN is refused
        vecs.push_back(mk(1, 1, 2, 0, 0, 0,   2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 0, 0, 0,   2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 0, 1, 0,   1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 0, 1, 0,   0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1));
        // abort in IDLE does not block a load
        vecs.push_back(mk(1, 1, 3, 0, 0, 1,   3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 1));
        // reset mid-RUN
        vecs.push_back(mk(1, 1, 9, 0, 1, 0,   9, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   8, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   7, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   6, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,   5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].lv, vecs[i].val, vecs[i].ar, vecs[i].en, vecs[i].ab);
            step();
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d tc", i), 32'(tc), 32'(vecs[i].e_tc));
            check($sformatf("vec%0d expirations", i), 32'(expirations), 32'(vecs[i].e_exp));
            check($sformatf("vec%0d load_ready", i), 32'(load_ready), 32'(vecs[i].e_rdy));
        end

        // auto-reload with load 3: expiry on every third enabled edge
        drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        step();
        check("ar load count", 32'(count), 32'd3);
        drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            int exp_cnt;
            exp_cnt = (k % 3 == 0) ? 3 : 3 - (k % 3);
            step();
            check($sformatf("ar edge%0d count", k), 32'(count), 32'(exp_cnt));
            check($sformatf("ar edge%0d tc", k), 32'(tc), (k % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("ar edge%0d busy", k), 32'(busy), 32'd1);
        end
        check("ar expirations", 32'(expirations), 32'd3);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        check("ar abort busy", 32'(busy), 32'd0);
        check("ar abort tc", 32'(tc), 32'd0);

        // saturation with load 1 and auto-reload
        drive(1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        step();
        check("sat load expirations", 32'(expirations), 32'd0);
        drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("sat edge%0d tc", k), 32'(tc), 32'd1);
            check($sformatf("sat edge%0d count", k), 32'(count), 32'd1);
            check($sformatf("sat edge%0d expirations", k), 32'(expirations),
                  (k > 15) ? 32'd15 : 32'(k));
        end
        drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        step();
        check("sat abort tc", 32'(tc), 32'd0);
        check("sat abort count", 32'(count), 32'd0);
        check("sat abort expirations", 32'(expirations), 32'd15);
        check("sat abort ready", 32'(load_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
